// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code consumer: pops FIFO bytes, decodes E0/F0 prefixes into key events, tracks held keys and modifiers.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses the event strobe for typematic makes.
module ps2_key_event_decoder #(
    parameter int          CNT_W    = 8,
    parameter logic [7:0]  EXT_CODE = 8'hE0,
    parameter logic [7:0]  BRK_CODE = 8'hF0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [7:0]       cur_key,
    output logic             cur_ext,
    output logic [CNT_W-1:0] key_count,
    output logic             shift_held,
    output logic             ctrl_held,
    output logic             caps_lock,
    output logic             err,
    output logic             ovf_seen
);

`ifdef PS2_REPEAT_FILTER_EN
    localparam bit REPEAT_FILTER = 1'b1;
`else
    localparam bit REPEAT_FILTER = 1'b0;
`endif

    typedef enum logic [1:0] {HS_RUN, HS_POP, HS_GAP} hs_state_t;
    typedef enum logic [1:0] {D_NORM, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

    hs_state_t  hs_state, hs_next;
    dec_state_t dec_state, dec_next;

    logic accept;
    logic is_evt, ev_ext, ev_brk, is_err;
    logic is_lsh, is_rsh, is_ctl, is_caps, is_mod, mod_held;
    logic cur_match, is_rep, emit;
    logic lshift_q, rshift_q, caps_down;

    assign accept     = (hs_state == HS_RUN) && ready;
    assign shift_held = lshift_q | rshift_q;

    // GAP absorbs the FIFO's pointer/ready update latency so no byte is popped twice.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        hs_next = hs_state;
        case (hs_state)
            HS_RUN:  if (ready) hs_next = HS_POP;
            HS_POP:  hs_next = HS_GAP;
            HS_GAP:  hs_next = HS_RUN;
            default: hs_next = HS_RUN;
        endcase
    end

    always_comb begin
        dec_next = dec_state;
        is_evt   = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        is_err   = 1'b0;
        if (data == 8'h00 || data == 8'hFF) begin
            is_err   = 1'b1;
            dec_next = D_NORM;
        end else if (data == EXT_CODE) begin
            is_err   = (dec_state != D_NORM);
            dec_next = D_EXT;
        end else if (data == BRK_CODE) begin
            case (dec_state)
                D_NORM:  dec_next = D_BRK;
                D_EXT:   dec_next = D_EXT_BRK;
                default: begin
                    is_err   = 1'b1;
                    dec_next = D_BRK;
                end
            endcase
        end else begin
            is_evt   = 1'b1;
            ev_ext   = (dec_state == D_EXT) || (dec_state == D_EXT_BRK);
            ev_brk   = (dec_state == D_BRK) || (dec_state == D_EXT_BRK);
            dec_next = D_NORM;
        end
    end

    // Modifiers never occupy cur_key; their own held flag decides whether a make is typematic.
    always_comb begin
        is_lsh    = (data == 8'h12) && !ev_ext;
        is_rsh    = (data == 8'h59) && !ev_ext;
        is_ctl    = (data == 8'h14);
        is_caps   = (data == 8'h58) && !ev_ext;
        is_mod    = is_lsh | is_rsh | is_ctl | is_caps;
        mod_held  = (is_lsh & lshift_q) | (is_rsh & rshift_q) | (is_ctl & ctrl_held) | (is_caps & caps_down);
        cur_match = (cur_key != 8'h00) && ({ev_ext, data} == {cur_ext, cur_key});
        is_rep    = is_evt && !ev_brk && (is_mod ? mod_held : cur_match);
        emit      = is_evt && !(REPEAT_FILTER && is_rep);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!clrn) begin
            hs_state   <= HS_RUN;
            dec_state  <= D_NORM;
            nextdata_n <= 1'b1;
            evt_valid  <= 1'b0;
            evt_code   <= 8'h00;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
            err        <= 1'b0;
            cur_key    <= 8'h00;
            cur_ext    <= 1'b0;
            key_count  <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            ctrl_held  <= 1'b0;
            caps_down  <= 1'b0;
            caps_lock  <= 1'b0;
            ovf_seen   <= 1'b0;
        end else begin
            hs_state   <= hs_next;
            nextdata_n <= (hs_next != HS_POP);
            ovf_seen   <= overflow;
            evt_valid  <= 1'b0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
            err        <= 1'b0;
            if (accept) begin
                dec_state <= dec_next;
                err       <= is_err;
                if (emit) begin
                    evt_valid  <= 1'b1;
                    evt_code   <= data;
                    evt_ext    <= ev_ext;
                    evt_break  <= ev_brk;
                    evt_repeat <= is_rep;
                end
                if (is_evt) begin
                    if (is_mod) begin
                        if (is_lsh)  lshift_q  <= !ev_brk;
                        if (is_rsh)  rshift_q  <= !ev_brk;
                        if (is_ctl)  ctrl_held <= !ev_brk;
                        if (is_caps) caps_down <= !ev_brk;
                        if (is_caps && !ev_brk && !caps_down) caps_lock <= !caps_lock;
                    end else if (!ev_brk) begin
                        if (!cur_match) begin
                            key_count <= key_count + CNT_W'(1);
                            cur_key   <= data;
                            cur_ext   <= ev_ext;
                        end
                    end else if (cur_match) begin
                        cur_key <= 8'h00;
                        cur_ext <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Consumer stage directly downstream of the PS/2 FIFO interface (ps2_keyboard). Pops scan-code bytes with the ready/nextdata_n handshake and decodes E0 (extended) and F0 (break) prefixes. Emits one-cycle key make/break events, tracks the held key, modifier state and a new-key counter. Outputs feed scancode_ram addressing and the display logic.

Parameters:
CNT_W, 8, width of key_count; wraps modulo 2^CNT_W.
EXT_CODE, 8'hE0, extended-key prefix byte.
BRK_CODE, 8'hF0, break prefix byte.

Ports:
clk  input  1  system clock; all logic on posedge.
clrn  input  1  synchronous active-low reset.
data  input  8  FIFO head byte from the PS/2 interface.
ready  input  1  FIFO non-empty.
overflow  input  1  sticky FIFO overflow from the PS/2 interface.
nextdata_n  output  1  active-low pop strobe, registered.
evt_valid  output  1  one-cycle event strobe.
evt_code  output  8  scan code of the event, without prefixes.
evt_ext  output  1  event had an E0 prefix.
evt_break  output  1  1 = release, 0 = press.
evt_repeat  output  1  make event for the currently held key (typematic).
cur_key  output  8  currently held non-modifier code; 0 = none.
cur_ext  output  1  extended flag of cur_key.
key_count  output  CNT_W  count of new non-modifier presses.
shift_held  output  1  left shift (12) or right shift (59) held.
ctrl_held  output  1  ctrl (14, extended or not) held.
caps_lock  output  1  toggle state.
err  output  1  one-cycle protocol-error strobe.
ovf_seen  output  1  registered copy of overflow.

Behaviour:
- Reset (clrn=0 at posedge): nextdata_n=1. evt_*, err, cur_key, cur_ext, key_count, shift_held, ctrl_held, caps_lock and ovf_seen are all 0. Handshake state = RUN, decode state = NORM. Reset mid-sequence discards any pending prefix.
- Handshake FSM: RUN -> POP -> GAP -> RUN.
  - RUN: if ready=1, latch data, go to POP. Otherwise stay in RUN.
  - POP: nextdata_n=0 for exactly this cycle; decoded event outputs are valid this cycle.
  - GAP: nextdata_n=1; ready is ignored, covering the interface's pointer and ready update latency.
  - Latency: ready sampled at edge t gives evt_valid/err at cycle t+1. Maximum throughput is 1 byte per 3 cycles. No byte is ever popped twice or skipped.
- Decode FSM (advances on each latched byte): states NORM, EXT, BRK, EXT_BRK.
  - NORM: E0 -> EXT; F0 -> BRK; otherwise make event, ext=0.
  - EXT: F0 -> EXT_BRK; otherwise make event, ext=1, -> NORM.
  - BRK: break event, ext=0, -> NORM.
  - EXT_BRK: break event, ext=1, -> NORM.
  - Errors:
    - E0 in EXT, BRK or EXT_BRK: err=1, -> EXT.
    - F0 in BRK or EXT_BRK: err=1, -> BRK.
    - Byte 00 or FF in any state: err=1, -> NORM, no event.
  - Prefix bytes never raise evt_valid.
- Held-key / count rules, applied at the event cycle:
  - Non-modifier make with {ext,code} == {cur_ext,cur_key} and cur_key != 0: evt_repeat=1, no count change.
  - Other non-modifier make: key_count += 1 (wraps), cur_key = code, cur_ext = ext.
  - Break matching {cur_ext,cur_key}: cur_key=0, cur_ext=0.
  - Break of any other key: no change to cur_key.
- Modifiers (12, 59, 14; ext ignored for 14; caps = 58 non-ext):
  - Modifiers still emit events but never touch cur_key or key_count.
  - A make sets the held flag; a break clears it. Shift tracks left and right independently and shift_held is their OR.
  - caps_lock toggles on a non-repeat make of 58 only; typematic makes do not toggle it.
- ovf_seen <= overflow every cycle. Decoding continues regardless of overflow.
- When not in POP: evt_* and err are 0, and evt_code holds its last value.

Optional Feature:
PS2_REPEAT_FILTER_EN
- Defined: typematic makes are swallowed (evt_valid stays 0); the byte is still popped and modifier flags still update.
- Undefined: repeats are emitted with evt_repeat=1.

Test Plan:
1. Reset, then FIFO bytes 1C, F0, 1C -> evt(1C, make, ext=0), key_count=1, cur_key=1C; then evt(1C, break), cur_key=00; exactly 3 nextdata_n pulses, each followed by 2 cycles with nextdata_n=1.
2. Bytes E0 75, E0 F0 75 -> make ext=1 code 75 then break ext=1; cur_ext returns to 0; key_count +1 only.
3. Bytes 1C 1C 1C F0 1C -> first make counted; next two have evt_repeat=1 (no evt_valid with PS2_REPEAT_FILTER_EN); key_count=1.
4. Bytes 12, 1C, F0 12, 58, 58, F0 58 -> shift_held 1 then 0; key_count=1 (1C only); caps_lock=1 after the first 58 and stays 1.
5. Bytes E0 E0 74, F0 F0 2B, FF -> err pulses at the second E0, the second F0 and FF; events decoded as make ext 74 and break 2B; decode state returns to NORM.
6. Assert clrn=0 between E0 and 74, release, send 74 -> all outputs return to reset values; 74 decodes as a make with ext=0; key_count=1. Separately, 256 distinct makes with CNT_W=8 -> key_count wraps to 0.
